// File: rtl/reg_debug_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared types and constants for the debug register-access block.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HALT = 2'd1,
        ACCESS    = 2'd2,
        RESP      = 2'd3
    } dbg_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_debug_access_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_debug_access_if
// Brief    : Command and response valid/ready channels between the debug
//            transport (master) and the register access block (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface reg_debug_access_if;
    import riscv_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [REG_ADDR_W-1:0] cmd_regno;
    logic [XLEN-1:0]       cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [XLEN-1:0]       rsp_rdata;
    logic                  rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_regno, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_regno, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/reg_debug_access_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : timeout_counter
// Brief    : Wrapping halt-wait counter; expired flags the last allowed cycle.
// Revision : 1.0 - initial release
// ============================================================================
module timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;

    // Count wait cycles; clear takes priority so each command starts at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign expired = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/reg_debug_access.sv
`default_nettype none
// ============================================================================
// Module   : reg_debug_access
// Brief    : Debug initiator: halts the core, performs one register-file
//            read or write, and returns a response.
// Revision : 1.0 - initial release
// ============================================================================
module reg_debug_access
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    reg_debug_access_if.slave          bus,
    output logic                       halt_req,
    input  wire logic                  core_halted,
    output logic                       rf_reg_write,
    output logic [REG_ADDR_W-1:0]      rf_write_reg,
    output logic [XLEN-1:0]            rf_write_data,
    output logic [REG_ADDR_W-1:0]      rf_read_reg,
    input  wire logic [XLEN-1:0]       rf_read_data
);

    dbg_state_t            r_state;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [XLEN-1:0]       r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_halt_req;
    logic                  r_write;
    logic [REG_ADDR_W-1:0] r_regno;
    logic [XLEN-1:0]       r_wdata;

    logic w_accept;
    logic w_expired;
    logic w_cnt_enable;

    assign w_accept     = (r_state == IDLE) && bus.cmd_valid;
    assign w_cnt_enable = (r_state == WAIT_HALT) && !core_halted && !w_expired;

    timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_accept),
        .enable  (w_cnt_enable),
        .expired (w_expired)
    );

    // Command FSM with registered handshake, halt and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_halt_req  <= 1'b0;
            r_write     <= 1'b0;
            r_regno     <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write     <= bus.cmd_write;
                        r_regno     <= bus.cmd_regno;
                        r_wdata     <= bus.cmd_wdata;
                        r_cmd_ready <= 1'b0;
                        r_halt_req  <= 1'b1;
                        r_state     <= WAIT_HALT;
                    end
                end
                WAIT_HALT: begin
                    // A halt arriving on the last count cycle still wins.
                    if (core_halted) begin
                        r_state <= ACCESS;
                    end else if (w_expired) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_halt_req  <= 1'b0;
                        r_state     <= RESP;
                    end
                end
                ACCESS: begin
                    r_rsp_valid <= 1'b1;
                    r_halt_req  <= 1'b0;
                    r_state     <= RESP;
                    if (core_halted) begin
                        r_rsp_err   <= 1'b0;
                        // x0 always reads as zero, whatever the file returns.
                        r_rsp_rdata <= (r_write || (r_regno == '0)) ? '0 : rf_read_data;
                    end else begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign halt_req      = r_halt_req;
    assign rf_write_reg  = r_regno;
    assign rf_read_reg   = r_regno;
    assign rf_write_data = r_wdata;
    // Write strobe only while the halt is still held in the access cycle.
    assign rf_reg_write  = (r_state == ACCESS) && r_write && core_halted;

endmodule
`default_nettype wire

// File: tb/tb_reg_debug_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_debug_access
// Brief    : Self-checking bench with a behavioural command/response model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_debug_access;
    import riscv_pkg::*;

    localparam int TMO = 4;

    logic            clk;
    logic            reset;
    logic            halt_req;
    logic            core_halted;
    logic            rf_reg_write;
    logic [4:0]      rf_write_reg;
    logic [31:0]     rf_write_data;
    logic [4:0]      rf_read_reg;
    logic [31:0]     rf_read_data;

    reg_debug_access_if bus ();

    reg_debug_access #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.slave),
        .halt_req      (halt_req),
        .core_halted   (core_halted),
        .rf_reg_write  (rf_reg_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_read_reg   (rf_read_reg),
        .rf_read_data  (rf_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain RAM standing in for the register file (x0 not hardwired here).
    logic [31:0] rf_mem [32];
    always @(posedge clk) if (rf_reg_write) rf_mem[rf_write_reg] <= rf_write_data;
    assign rf_read_data = rf_mem[rf_read_reg];

    // Architectural view: what each register should read back as.
    logic [31:0] model [32];

    int n_tests = 0;
    int n_fail  = 0;

    logic        nxt_wr;
    logic [4:0]  nxt_rn;
    logic [31:0] nxt_wd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called in the clock-low phase; returns in the clock-low phase.
    // hd: wait cycles before core_halted rises (-1 = never); drop: halt lost in ACCESS.
    task automatic run_cmd(input bit wr, input logic [4:0] rn, input logic [31:0] wd,
                           input int hd, input bit drop, input int hold, input bit pend);
        int          k;
        int          lat;
        int          pulses;
        logic [4:0]  paddr;
        logic [31:0] pdata;
        bit          halted_ok;
        bit          exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;

        halted_ok = (hd >= 0) && (hd <= TMO - 1);
        exp_err   = !halted_ok || drop;
        exp_rd    = (exp_err || wr || rn == 5'd0) ? 32'd0 : model[rn];
        exp_lat   = halted_ok ? hd + 3 : TMO + 1;
        paddr     = '0;
        pdata     = '0;

        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_regno = rn;
        bus.cmd_wdata = wd;
        core_halted   = (hd == 0);
        #1;
        check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        k = 0; lat = 0; pulses = 0;
        while (lat == 0 && k < 200) begin
            @(negedge clk);
            if (pend) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_write = nxt_wr;
                bus.cmd_regno = nxt_rn;
                bus.cmd_wdata = nxt_wd;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            core_halted = (hd >= 0) && (k >= hd) && !(drop && k > hd);
            #1;
            if (rf_reg_write) begin
                pulses++;
                paddr = rf_write_reg;
                pdata = rf_write_data;
            end
            if (bus.rsp_valid) begin
                lat = k + 1;
            end else begin
                check("halt_req_busy", 32'(halt_req), 32'd1);
                check("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
            end
            k++;
        end
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        check("rsp_rdata", bus.rsp_rdata, exp_rd);
        check("halt_req_resp", 32'(halt_req), 32'd0);
        check("write_pulses", 32'(pulses), (wr && !exp_err) ? 32'd1 : 32'd0);
        if (pulses == 1) begin
            check("write_addr", 32'(paddr), 32'(rn));
            check("write_data", pdata, wd);
        end
        if (wr && !exp_err) model[rn] = wd;

        bus.rsp_ready = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            #1;
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rdata", bus.rsp_rdata, exp_rd);
            check("hold_err", 32'(bus.rsp_err), 32'(exp_err));
            check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        if (!pend) bus.cmd_valid = 1'b0;
        core_halted = 1'b0;
        #1;
        check("rsp_done_valid", 32'(bus.rsp_valid), 32'd0);
        check("rsp_done_ready", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = $urandom;
            model[i]  = rf_mem[i];
        end
        reset         = 1'b1;
        core_halted   = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_regno = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        nxt_wr = 1'b0; nxt_rn = '0; nxt_wd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_halt_req", 32'(halt_req), 32'd0);
        check("rst_rf_write", 32'(rf_reg_write), 32'd0);
        check("rst_rf_wreg", 32'(rf_write_reg), 32'd0);
        check("rst_rf_wdata", rf_write_data, 32'd0);
        check("rst_rf_rreg", 32'(rf_read_reg), 32'd0);

        // Directed cases.
        rf_mem[5] = 32'hDEADBEEF;
        model[5]  = 32'hDEADBEEF;
        run_cmd(1'b0, 5'd5,  32'd0,         0, 1'b0, 0, 1'b0);
        run_cmd(1'b1, 5'd31, 32'h12345678,  0, 1'b0, 0, 1'b0);
        run_cmd(1'b0, 5'd31, 32'd0,         0, 1'b0, 0, 1'b0);
        run_cmd(1'b1, 5'd0,  32'hFFFFFFFF,  0, 1'b0, 0, 1'b0);
        run_cmd(1'b0, 5'd0,  32'd0,         0, 1'b0, 0, 1'b0);
        run_cmd(1'b0, 5'd7,  32'd0,        -1, 1'b0, 0, 1'b0);
        run_cmd(1'b1, 5'd9,  32'hAAAA5555,  1, 1'b1, 0, 1'b0);
        run_cmd(1'b0, 5'd9,  32'd0,         0, 1'b0, 0, 1'b0);
        run_cmd(1'b0, 5'd12, 32'd0,   TMO - 1, 1'b0, 0, 1'b0);
        run_cmd(1'b1, 5'd13, 32'h0BADF00D, TMO, 1'b0, 0, 1'b0);

        // Backpressure with a second command already waiting.
        nxt_wr = 1'b0; nxt_rn = 5'd31; nxt_wd = 32'd0;
        run_cmd(1'b1, 5'd12, 32'hCAFEF00D, 0, 1'b0, 10, 1'b1);
        run_cmd(1'b0, 5'd31, 32'd0,        0, 1'b0, 0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            int hd;
            hd = int'($urandom_range(0, 6));
            if (hd == 6) hd = -1;
            run_cmd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                    hd, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset while waiting for halt.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_regno = 5'd3;
        bus.cmd_wdata = 32'h55AA55AA;
        core_halted   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("mid_halt_req", 32'(halt_req), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_halt_req", 32'(halt_req), 32'd0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("mid_rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("mid_rst_rf_write", 32'(rf_reg_write), 32'd0);
        check("mid_rst_rf_wreg", 32'(rf_write_reg), 32'd0);
        check("mid_rst_rf_wdata", rf_write_data, 32'd0);
        check("mid_rst_rf_rreg", 32'(rf_read_reg), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
            check("post_rst_no_halt", 32'(halt_req), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
